// File: rtl/chroma_calib_ctrl_if.sv
// HSV pixel stream, calibration request and calibrated-threshold bundle
// shared between the chroma keyer side and the calibration controller.
interface chroma_calib_ctrl_if;
  logic        vsync;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [23:0] hsv_in;
  logic        start;
  logic        busy;
  logic [7:0]  cal_h;
  logic [7:0]  cal_s;
  logic [7:0]  cal_v;
  logic        cal_load;
  logic        cal_err;

  modport master (
    output vsync, hcount, vcount, hsv_in, start,
    input  busy, cal_h, cal_s, cal_v, cal_load, cal_err
  );

  modport slave (
    input  vsync, hcount, vcount, hsv_in, start,
    output busy, cal_h, cal_s, cal_v, cal_load, cal_err
  );
endinterface

// File: rtl/chroma_calib_ctrl.sv
// Chroma keyer auto-calibration: averages H/S/V over a square window for
// 2^FRAMES_LOG2 frames and loads the truncated means with a one-cycle strobe.
module chroma_calib_ctrl #(
  parameter int         WIN_X0      = 312,
  parameter int         WIN_Y0      = 232,
  parameter int         WIN_LOG2    = 4,
  parameter int         FRAMES_LOG2 = 2,
  parameter logic [7:0] H_DEF       = 8'd85,
  parameter logic [7:0] S_DEF       = 8'd94,
  parameter logic [7:0] V_DEF       = 8'd202
) (
  input logic           clk,
  input logic           rst,
  chroma_calib_ctrl_if.slave bus
);

  localparam int SH = 2 * WIN_LOG2 + FRAMES_LOG2;
  localparam int AW = 8 + SH;
  localparam int CW = SH + 1;
  localparam int FW = (FRAMES_LOG2 > 0) ? FRAMES_LOG2 : 1;

  localparam logic [CW-1:0] N_EXP  = {1'b1, {SH{1'b0}}};
  localparam logic [FW-1:0] F_LAST = FW'((2 ** FRAMES_LOG2) - 1);
  localparam logic [11:0]   X_LO   = 12'(WIN_X0);
  localparam logic [11:0]   X_HI   = 12'(WIN_X0 + 2 ** WIN_LOG2);
  localparam logic [10:0]   Y_LO   = 11'(WIN_Y0);
  localparam logic [10:0]   Y_HI   = 11'(WIN_Y0 + 2 ** WIN_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_ACCUM,
    S_CHECK,
    S_LOAD
  } state_t;

  state_t          r_state;
  logic            r_vsync_q;
  logic            r_busy;
  logic            r_load;
  logic            r_err;
  logic [7:0]      r_cal_h;
  logic [7:0]      r_cal_s;
  logic [7:0]      r_cal_v;
  logic [CW-1:0]   r_cnt;
  logic [FW-1:0]   r_frame;

  logic            w_fall;
  logic            w_hit;
  logic            w_acc_clr;
  logic            w_acc_en;
  logic [2:0][7:0] w_mean;

  assign w_fall = r_vsync_q & ~bus.vsync;

  // Zero-extended compares so a window near the top of the count range never wraps.
  assign w_hit = ({1'b0, bus.hcount} >= X_LO) && ({1'b0, bus.hcount} < X_HI) &&
                 ({1'b0, bus.vcount} >= Y_LO) && ({1'b0, bus.vcount} < Y_HI);

  assign w_acc_clr = rst || ((r_state == S_WAIT_FRAME) && w_fall);
  assign w_acc_en  = (r_state == S_ACCUM) && w_hit;

  // Channel 0 = H, 1 = S, 2 = V; the mean is the top 8 bits of each sum.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [AW-1:0] r_acc;
      logic [7:0]    w_pix;

      assign w_pix = bus.hsv_in[8*(2-gi) +: 8];

      always_ff @(posedge clk) begin
        if (w_acc_clr) begin
          r_acc <= '0;
        end else if (w_acc_en) begin
          r_acc <= r_acc + {{SH{1'b0}}, w_pix};
        end
      end

      assign w_mean[gi] = r_acc[AW-1:SH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vsync_q <= 1'b0;
      r_busy    <= 1'b0;
      r_load    <= 1'b0;
      r_err     <= 1'b0;
      r_cal_h   <= H_DEF;
      r_cal_s   <= S_DEF;
      r_cal_v   <= V_DEF;
      r_cnt     <= '0;
      r_frame   <= '0;
    end else begin
      r_vsync_q <= bus.vsync;
      r_load    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_frame <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_hit) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_fall) begin
            if (r_frame == F_LAST) begin
              r_state <= S_CHECK;
            end else begin
              r_frame <= r_frame + 1'b1;
            end
          end
        end
        S_CHECK: begin
          // Outputs are registered, so the means and strobe are launched here
          // and are visible for exactly the LOAD cycle.
          if (r_cnt == N_EXP) begin
            r_cal_h <= w_mean[0];
            r_cal_s <= w_mean[1];
            r_cal_v <= w_mean[2];
            r_load  <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.cal_load = r_load;
  assign bus.cal_err  = r_err;
  assign bus.cal_h    = r_cal_h;
  assign bus.cal_s    = r_cal_s;
  assign bus.cal_v    = r_cal_v;

endmodule

// File: tb/tb_chroma_calib_ctrl.sv
// Directed bench: a 2x2-window, 2-frame controller plus an identical one whose
// window is never hit, both driven by the same pixel stream.
module tb_chroma_calib_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [23:0] hsv = '0;
  logic        start = 1'b0;

  int errors = 0;
  int checks = 0;
  int a_loads = 0;
  int b_loads = 0;

  logic [23:0] pix_tab [8];

  always #5 clk = ~clk;

  chroma_calib_ctrl_if bus_a();
  chroma_calib_ctrl_if bus_b();

  assign bus_a.vsync  = vsync;
  assign bus_a.hcount = hcount;
  assign bus_a.vcount = vcount;
  assign bus_a.hsv_in = hsv;
  assign bus_a.start  = start;
  assign bus_b.vsync  = vsync;
  assign bus_b.hcount = hcount;
  assign bus_b.vcount = vcount;
  assign bus_b.hsv_in = hsv;
  assign bus_b.start  = start;

  chroma_calib_ctrl #(
    .WIN_X0(4), .WIN_Y0(2), .WIN_LOG2(1), .FRAMES_LOG2(1)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  chroma_calib_ctrl #(
    .WIN_X0(2000), .WIN_Y0(2), .WIN_LOG2(1), .FRAMES_LOG2(1)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  always @(negedge clk) begin
    if (bus_a.cal_load === 1'b1) a_loads++;
    if (bus_b.cal_load === 1'b1) b_loads++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one cycle of stimulus; returns 1 ns into the following cycle.
  task automatic cyc(input logic vs, input int x, input int y, input logic [23:0] p,
                     input logic st);
    vsync  = vs;
    hcount = 11'(x);
    vcount = 10'(y);
    hsv    = p;
    start  = st;
    @(posedge clk);
    #1;
  endtask

  // One calibration run of two frames over pix_tab, with latency checks
  // around the terminating fall.
  task automatic do_run(input string name, input bit entry_hit, input bit last_on_fall,
                        input bit start_mid, input bit hold_start,
                        input int eh, input int es, input int ev);
    int loads0;
    int bloads0;
    int k;
    loads0  = a_loads;
    bloads0 = b_loads;
    cyc(1'b1, 0, 0, 24'h0, 1'b1);
    check_val({name, ".busy_after_start"}, int'(bus_a.busy), 1);
    check_val({name, ".err_cleared_b"}, int'(bus_b.cal_err), 0);
    // entry fall cycle; a window pixel here must not be accumulated
    if (entry_hit) cyc(1'b0, 4, 2, 24'hFF0000, 1'b0);
    else           cyc(1'b0, 0, 0, 24'h0, 1'b0);
    k = 0;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 4; j++) begin
        if (!(f == 1 && j == 3 && last_on_fall)) begin
          cyc(1'b0, 4 + j % 2, 2 + j / 2, pix_tab[k], start_mid && (k == 0));
          k++;
        end
      end
      cyc(1'b1, 0, 0, 24'h0, 1'b0);
      if (f == 1 && last_on_fall) cyc(1'b0, 5, 3, pix_tab[7], 1'b0);
      else                        cyc(1'b0, 0, 0, 24'h0, 1'b0);
    end
    // cycle t+1: CHECK
    check_val({name, ".load_t1"}, int'(bus_a.cal_load), 0);
    check_val({name, ".busy_t1"}, int'(bus_a.busy), 1);
    cyc(1'b0, 0, 0, 24'h0, hold_start);
    // cycle t+2: LOAD
    check_val({name, ".load_t2"}, int'(bus_a.cal_load), 1);
    check_val({name, ".busy_t2"}, int'(bus_a.busy), 1);
    check_val({name, ".cal_h"}, int'(bus_a.cal_h), eh);
    check_val({name, ".cal_s"}, int'(bus_a.cal_s), es);
    check_val({name, ".cal_v"}, int'(bus_a.cal_v), ev);
    check_val({name, ".err"}, int'(bus_a.cal_err), 0);
    check_val({name, ".err_b"}, int'(bus_b.cal_err), 1);
    check_val({name, ".busy_b"}, int'(bus_b.busy), 0);
    check_val({name, ".cal_h_b"}, int'(bus_b.cal_h), 85);
    check_val({name, ".cal_s_b"}, int'(bus_b.cal_s), 94);
    check_val({name, ".cal_v_b"}, int'(bus_b.cal_v), 202);
    cyc(1'b0, 0, 0, 24'h0, hold_start);
    // cycle t+3: back in IDLE
    check_val({name, ".load_t3"}, int'(bus_a.cal_load), 0);
    check_val({name, ".busy_t3"}, int'(bus_a.busy), 0);
    if (hold_start) begin
      cyc(1'b0, 0, 0, 24'h0, 1'b1);
      check_val({name, ".restart_busy"}, int'(bus_a.busy), 1);
      start = 1'b0;
    end
    check_val({name, ".load_pulses"}, a_loads - loads0, 1);
    check_val({name, ".load_pulses_b"}, b_loads - bloads0, 0);
    $display("run %s: cal=%0d/%0d/%0d err=%0d, b err=%0d", name, bus_a.cal_h,
             bus_a.cal_s, bus_a.cal_v, bus_a.cal_err, bus_b.cal_err);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) cyc(1'b0, 0, 0, 24'h0, 1'b0);
    check_val("rst.busy", int'(bus_a.busy), 0);
    check_val("rst.load", int'(bus_a.cal_load), 0);
    check_val("rst.err", int'(bus_a.cal_err), 0);
    check_val("rst.cal_h", int'(bus_a.cal_h), 85);
    check_val("rst.cal_s", int'(bus_a.cal_s), 94);
    check_val("rst.cal_v", int'(bus_a.cal_v), 202);
    rst = 1'b0;
    cyc(1'b0, 0, 0, 24'h0, 1'b0);
    $display("reset: busy=%0d cal=%0d/%0d/%0d", bus_a.busy, bus_a.cal_h, bus_a.cal_s,
             bus_a.cal_v);

    // constant pixels 0x3C80F0 -> 60/128/240
    for (int i = 0; i < 8; i++) pix_tab[i] = 24'h3C80F0;
    do_run("const", 1'b0, 1'b0, 1'b0, 1'b0, 60, 128, 240);

    // H 10/11 alternating -> 10 (84/8); S all 255; V 1..8 -> 4 (36/8);
    // red pixel on entry fall excluded, last sample on the final fall included
    for (int i = 0; i < 8; i++) pix_tab[i] = {8'(10 + i % 2), 8'd255, 8'(i + 1)};
    do_run("trunc", 1'b1, 1'b1, 1'b0, 1'b0, 10, 255, 4);

    // H 100; S 8*i -> 28 (224/8); V 200+i -> 203 (1628/8); start pulsed mid-run
    // and held across LOAD
    for (int i = 0; i < 8; i++) pix_tab[i] = {8'd100, 8'(8 * i), 8'(200 + i)};
    do_run("busy", 1'b0, 1'b0, 1'b1, 1'b1, 100, 28, 203);

    // reset in the middle of ACCUM
    cyc(1'b1, 0, 0, 24'h0, 1'b0);
    cyc(1'b0, 0, 0, 24'h0, 1'b0);
    cyc(1'b0, 4, 2, 24'h123456, 1'b0);
    cyc(1'b0, 5, 2, 24'h123456, 1'b0);
    check_val("mid.busy_pre", int'(bus_a.busy), 1);
    rst = 1'b1;
    cyc(1'b0, 4, 3, 24'h123456, 1'b0);
    rst = 1'b0;
    check_val("mid.busy", int'(bus_a.busy), 0);
    check_val("mid.load", int'(bus_a.cal_load), 0);
    check_val("mid.cal_h", int'(bus_a.cal_h), 85);
    check_val("mid.cal_s", int'(bus_a.cal_s), 94);
    check_val("mid.cal_v", int'(bus_a.cal_v), 202);
    cyc(1'b0, 0, 0, 24'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_val("nofall.busy", int'(bus_a.busy), 1);
      check_val("nofall.load", int'(bus_a.cal_load), 0);
      cyc(1'b0, 4, 2, 24'h0, 1'b0);
    end
    $display("reset mid-run: busy=%0d cal=%0d/%0d/%0d", bus_a.busy, bus_a.cal_h,
             bus_a.cal_s, bus_a.cal_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chroma_calib_ctrl.md
# chroma_calib_ctrl

Auto-calibration controller for the chroma keyer. When the user requests it, the block samples a fixed square window of the HSV pixel stream for a power-of-two number of frames. It computes the mean H, S and V over that window and loads them into the keyer's nominal thresholds through a one-cycle load strobe. It sits beside the keyer on the HSV pixel stream and runs from the same clock and vsync as the keyer.

## Interface

Parameters:
- WIN_X0, 312, left column of the calibration window (hcount units)
- WIN_Y0, 232, top row of the calibration window (vcount units)
- WIN_LOG2, 4, window side = 2^WIN_LOG2 pixels (16x16 default)
- FRAMES_LOG2, 2, number of frames averaged = 2^FRAMES_LOG2
- H_DEF / S_DEF / V_DEF, 85 / 94 / 202, reset values of the calibrated outputs

Ports (reset rst is synchronous and active-high; clock is clk):
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- vsync  in  1  frame sync; a frame boundary is a vsync falling edge
- hcount  in  11  column of hsv_in
- vcount  in  10  row of hsv_in
- hsv_in  in  24  {H[23:16], S[15:8], V[7:0]}, aligned with hcount/vcount
- start  in  1  calibration request; level is sampled only in IDLE
- busy  out  1  high in every state except IDLE
- cal_h / cal_s / cal_v  out  8 each  calibrated nominal values to the keyer
- cal_load  out  1  one-cycle strobe; the keyer latches cal_* on it
- cal_err  out  1  sticky; set when the sample count mismatches, cleared by the next start

## Operation

- Edge detect: vsync_q <= vsync. fall = vsync_q & ~vsync.
- Window hit: WIN_X0 <= hcount < WIN_X0+2^WIN_LOG2 and WIN_Y0 <= vcount < WIN_Y0+2^WIN_LOG2.
- Accumulator width: AW = 8 + 2*WIN_LOG2 + FRAMES_LOG2. There are three accumulators (h, s, v), each AW bits.
- Sample counter: 2*WIN_LOG2+FRAMES_LOG2+1 bits, so that the expected total N = 2^(2*WIN_LOG2+FRAMES_LOG2) is representable without wrap.
- FSM:
  - IDLE: on start=1, clear cal_err and go to WAIT_FRAME.
  - WAIT_FRAME: on fall, clear the accumulators, the sample counter and frame_cnt, then go to ACCUM.
  - ACCUM:
    - Each cycle with a window hit, add H, S and V to their accumulators and increment the sample counter.
    - On fall, increment frame_cnt. If frame_cnt was 2^FRAMES_LOG2-1, go to CHECK instead.
  - CHECK (1 cycle):
    - If sample count == N, go to LOAD.
    - Otherwise set cal_err and go to IDLE. cal_* is unchanged and no strobe is issued.
  - LOAD (1 cycle): cal_h/s/v <= accumulator >> (2*WIN_LOG2+FRAMES_LOG2), so the mean is truncated. Assert cal_load, then go to IDLE.
- Mean is arithmetic with no hue circular handling; a hue window straddling 0/255 averages to mid-range. This is accepted and documented.
- start while busy is ignored, with no restart and no queuing.
- rst at any time:
  - FSM returns to IDLE.
  - busy=0, cal_load=0, cal_err=0.
  - cal_h/s/v = H_DEF/S_DEF/V_DEF.
  - Accumulators and counters are cleared.

## Timing

- Reset values: busy 0, cal_load 0, cal_err 0, cal_h 85, cal_s 94, cal_v 202 (at default parameters).
- start is seen at edge k; busy=1 from cycle k+1.
- The pixel presented in the same cycle as the fall that enters ACCUM is not accumulated. Window pixels are accumulated from the next cycle on.
- A window pixel coinciding with the terminating fall is accumulated.
- Final fall at edge t: CHECK runs in cycle t+1. cal_* updates and cal_load=1 in cycle t+2. busy=0 from cycle t+3.
- A fall arriving while in CHECK or LOAD is ignored.
- Max sum 255*N fits in AW bits, so there is no overflow.

## Test plan

- Reset: assert rst mid-ACCUM → next cycle busy=0, cal_h/s/v=85/94/202, cal_load=0; a following start with no fall keeps busy=1 and cal_load never pulses.
- Constant pixels: WIN_LOG2=1, FRAMES_LOG2=1, hsv_in=0x3C80F0 everywhere, 3 falls with full windows → cal_load one cycle, cal=60/128/240, cal_err=0.
- Truncation: same small parameters, H alternating 10/11 across the 8 window samples → cal_h=10; S all 255 → cal_s=255 with no overflow.
- Sample mismatch: window placed at WIN_X0=2000 (never hit) → CHECK sets cal_err=1, no cal_load, cal_* keeps its previous values; the next start clears cal_err.
- Busy/start: pulse start during ACCUM → no restart, load occurs after the original frame count. Start held high across LOAD → a new run begins from IDLE the cycle after LOAD.
- Latency: final fall at edge t → cal_load high only at t+2, busy low at t+3; a pixel in-window on the entry-fall cycle is excluded from the mean (verify with a distinct value 0xFF0000 at that cycle: cal_h unaffected).
